// File: rtl/hp_axi_arbiter.sv
// hp_axi_arbiter: two-master arbiter in front of a single Zynq S_AXI HP port.
// AR and AW are arbitrated independently (round-robin, registered output),
// W follows AW grant order through a small master-index FIFO, and R/B are
// steered back by the MSB of the response ID.
// Optional build macro: HP_ARB_ADDR_REMAP_EN places both masters in the
// DDR window at 0x1000_0000 (addr[31:28] forced to 4'd1).

// Address-channel arbiter: IDLE selects and captures, HOLD presents to slave.
module hp_axi_arb_addr #(
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            allow,
  input  logic            m0_valid,
  input  logic [31:0]     m0_addr,
  input  logic [ID_W-1:0] m0_id,
  input  logic [7:0]      m0_len,
  input  logic [2:0]      m0_size,
  output logic            m0_ready,
  input  logic            m1_valid,
  input  logic [31:0]     m1_addr,
  input  logic [ID_W-1:0] m1_id,
  input  logic [7:0]      m1_len,
  input  logic [2:0]      m1_size,
  output logic            m1_ready,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [31:0]     s_addr,
  output logic [ID_W:0]   s_id,
  output logic [7:0]      s_len,
  output logic [2:0]      s_size,
  output logic            grant,
  output logic            grant_mst
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [31:0]   addr_q, addr_d;
  logic [ID_W:0] id_q, id_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;

  // Next-state, grant selection and payload capture.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    size_d    = size_q;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    grant     = 1'b0;
    grant_mst = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gates the grant so no master sees ready while in reset
        if (reset_n && allow && (m0_valid || m1_valid)) begin
          grant_mst = (m0_valid && m1_valid) ? prio_q : m1_valid;
          grant     = 1'b1;
          state_d   = HOLD;
          if (grant_mst) begin
            m1_ready = 1'b1;
            addr_d   = m1_addr;
            id_d     = {1'b1, m1_id};
            len_d    = m1_len;
            size_d   = m1_size;
          end else begin
            m0_ready = 1'b1;
            addr_d   = m0_addr;
            id_d     = {1'b0, m0_id};
            len_d    = m0_len;
            size_d   = m0_size;
          end
        end
      end
      HOLD: begin
        if (s_ready) begin
          state_d = IDLE;
          prio_d  = ~id_q[ID_W];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, priority and payload registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
    end
  end

  assign s_valid = (state_q == HOLD);
  assign s_addr  = addr_q;
  assign s_id    = id_q;
  assign s_len   = len_q;
  assign s_size  = size_q;

endmodule

module hp_axi_arbiter #(
  parameter int ID_W            = 5,
  parameter int WORD_FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  // master 0
  input  logic            m0_ar_valid,
  output logic            m0_ar_ready,
  input  logic [31:0]     m0_ar_addr,
  input  logic [ID_W-1:0] m0_ar_id,
  input  logic [7:0]      m0_ar_len,
  input  logic [2:0]      m0_ar_size,
  input  logic            m0_aw_valid,
  output logic            m0_aw_ready,
  input  logic [31:0]     m0_aw_addr,
  input  logic [ID_W-1:0] m0_aw_id,
  input  logic [7:0]      m0_aw_len,
  input  logic [2:0]      m0_aw_size,
  input  logic            m0_w_valid,
  output logic            m0_w_ready,
  input  logic [63:0]     m0_w_data,
  input  logic            m0_w_last,
  output logic            m0_r_valid,
  input  logic            m0_r_ready,
  output logic [63:0]     m0_r_data,
  output logic [ID_W-1:0] m0_r_id,
  output logic [1:0]      m0_r_resp,
  output logic            m0_r_last,
  output logic            m0_b_valid,
  input  logic            m0_b_ready,
  output logic [ID_W-1:0] m0_b_id,
  output logic [1:0]      m0_b_resp,
  // master 1
  input  logic            m1_ar_valid,
  output logic            m1_ar_ready,
  input  logic [31:0]     m1_ar_addr,
  input  logic [ID_W-1:0] m1_ar_id,
  input  logic [7:0]      m1_ar_len,
  input  logic [2:0]      m1_ar_size,
  input  logic            m1_aw_valid,
  output logic            m1_aw_ready,
  input  logic [31:0]     m1_aw_addr,
  input  logic [ID_W-1:0] m1_aw_id,
  input  logic [7:0]      m1_aw_len,
  input  logic [2:0]      m1_aw_size,
  input  logic            m1_w_valid,
  output logic            m1_w_ready,
  input  logic [63:0]     m1_w_data,
  input  logic            m1_w_last,
  output logic            m1_r_valid,
  input  logic            m1_r_ready,
  output logic [63:0]     m1_r_data,
  output logic [ID_W-1:0] m1_r_id,
  output logic [1:0]      m1_r_resp,
  output logic            m1_r_last,
  output logic            m1_b_valid,
  input  logic            m1_b_ready,
  output logic [ID_W-1:0] m1_b_id,
  output logic [1:0]      m1_b_resp,
  // slave (PS S_AXI HP)
  output logic            s_ar_valid,
  input  logic            s_ar_ready,
  output logic [31:0]     s_ar_addr,
  output logic [ID_W:0]   s_ar_id,
  output logic [7:0]      s_ar_len,
  output logic [2:0]      s_ar_size,
  output logic            s_aw_valid,
  input  logic            s_aw_ready,
  output logic [31:0]     s_aw_addr,
  output logic [ID_W:0]   s_aw_id,
  output logic [7:0]      s_aw_len,
  output logic [2:0]      s_aw_size,
  output logic            s_w_valid,
  input  logic            s_w_ready,
  output logic [63:0]     s_w_data,
  output logic            s_w_last,
  input  logic            s_r_valid,
  output logic            s_r_ready,
  input  logic [63:0]     s_r_data,
  input  logic [ID_W:0]   s_r_id,
  input  logic [1:0]      s_r_resp,
  input  logic            s_r_last,
  input  logic            s_b_valid,
  output logic            s_b_ready,
  input  logic [ID_W:0]   s_b_id,
  input  logic [1:0]      s_b_resp
);

  localparam int PW = $clog2(WORD_FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(WORD_FIFO_DEPTH);

  function automatic logic [31:0] remap_addr(input logic [31:0] a);
`ifdef HP_ARB_ADDR_REMAP_EN
    return (a & 32'h0FFF_FFFF) | 32'h1000_0000;
`else
    return a;
`endif
  endfunction

  logic [31:0] ar_addr_raw, aw_addr_raw;
  logic        ar_grant, ar_mst;
  logic        aw_grant, aw_mst;

  logic [WORD_FIFO_DEPTH-1:0] mst_q, mst_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]                cnt_q, cnt_d;
  logic                       fifo_full, fifo_empty, head, push, pop;

  hp_axi_arb_addr #(.ID_W(ID_W)) u_ar (
    .clk(clk), .reset_n(reset_n), .allow(1'b1),
    .m0_valid(m0_ar_valid), .m0_addr(m0_ar_addr), .m0_id(m0_ar_id),
    .m0_len(m0_ar_len), .m0_size(m0_ar_size), .m0_ready(m0_ar_ready),
    .m1_valid(m1_ar_valid), .m1_addr(m1_ar_addr), .m1_id(m1_ar_id),
    .m1_len(m1_ar_len), .m1_size(m1_ar_size), .m1_ready(m1_ar_ready),
    .s_valid(s_ar_valid), .s_ready(s_ar_ready), .s_addr(ar_addr_raw),
    .s_id(s_ar_id), .s_len(s_ar_len), .s_size(s_ar_size),
    .grant(ar_grant), .grant_mst(ar_mst)
  );

  // AW may only grant while the W-order FIFO has room for the new burst
  hp_axi_arb_addr #(.ID_W(ID_W)) u_aw (
    .clk(clk), .reset_n(reset_n), .allow(~fifo_full),
    .m0_valid(m0_aw_valid), .m0_addr(m0_aw_addr), .m0_id(m0_aw_id),
    .m0_len(m0_aw_len), .m0_size(m0_aw_size), .m0_ready(m0_aw_ready),
    .m1_valid(m1_aw_valid), .m1_addr(m1_aw_addr), .m1_id(m1_aw_id),
    .m1_len(m1_aw_len), .m1_size(m1_aw_size), .m1_ready(m1_aw_ready),
    .s_valid(s_aw_valid), .s_ready(s_aw_ready), .s_addr(aw_addr_raw),
    .s_id(s_aw_id), .s_len(s_aw_len), .s_size(s_aw_size),
    .grant(aw_grant), .grant_mst(aw_mst)
  );

  assign s_ar_addr = remap_addr(ar_addr_raw);
  assign s_aw_addr = remap_addr(aw_addr_raw);

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign head       = mst_q[rd_ptr_q];
  assign push       = aw_grant;
  assign pop        = s_w_valid & s_w_ready & s_w_last;

  // W-order FIFO update: push granted master index, pop on last W beat.
  always_comb begin
    mst_d    = mst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mst_d[wr_ptr_q] = aw_mst;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO registers; only pointers and count need a defined reset value.
  always_ff @(posedge clk) begin
    mst_q <= mst_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // W path: head-of-FIFO master owns the channel, the other is stalled
  assign s_w_valid  = ~fifo_empty & (head ? m1_w_valid : m0_w_valid);
  assign s_w_data   = head ? m1_w_data : m0_w_data;
  assign s_w_last   = head ? m1_w_last : m0_w_last;
  assign m0_w_ready = ~fifo_empty & ~head & s_w_ready;
  assign m1_w_ready = ~fifo_empty &  head & s_w_ready;

  // R path: ID MSB selects the master, remaining ID bits go back unchanged
  assign m0_r_valid = s_r_valid & ~s_r_id[ID_W];
  assign m1_r_valid = s_r_valid &  s_r_id[ID_W];
  assign s_r_ready  = s_r_id[ID_W] ? m1_r_ready : m0_r_ready;
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_id    = s_r_id[ID_W-1:0];
  assign m1_r_id    = s_r_id[ID_W-1:0];
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;

  // B path: same steering as R
  assign m0_b_valid = s_b_valid & ~s_b_id[ID_W];
  assign m1_b_valid = s_b_valid &  s_b_id[ID_W];
  assign s_b_ready  = s_b_id[ID_W] ? m1_b_ready : m0_b_ready;
  assign m0_b_id    = s_b_id[ID_W-1:0];
  assign m1_b_id    = s_b_id[ID_W-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;

endmodule

// File: tb/tb_hp_axi_arbiter.sv
// Directed self-checking bench for hp_axi_arbiter (ID_W=5, depth 4).
module tb_hp_axi_arbiter;

  localparam int ID_W = 5;

`ifdef HP_ARB_ADDR_REMAP_EN
  localparam logic [31:0] EXP_AR_ADDR = 32'h1000_1000;
`else
  localparam logic [31:0] EXP_AR_ADDR = 32'h0000_1000;
`endif

  logic clk = 1'b0;
  logic reset_n;

  logic            m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [31:0]     m0_ar_addr, m1_ar_addr;
  logic [ID_W-1:0] m0_ar_id, m1_ar_id;
  logic [7:0]      m0_ar_len, m1_ar_len;
  logic [2:0]      m0_ar_size, m1_ar_size;
  logic            m0_aw_valid, m0_aw_ready, m1_aw_valid, m1_aw_ready;
  logic [31:0]     m0_aw_addr, m1_aw_addr;
  logic [ID_W-1:0] m0_aw_id, m1_aw_id;
  logic [7:0]      m0_aw_len, m1_aw_len;
  logic [2:0]      m0_aw_size, m1_aw_size;
  logic            m0_w_valid, m0_w_ready, m0_w_last, m1_w_valid, m1_w_ready, m1_w_last;
  logic [63:0]     m0_w_data, m1_w_data;
  logic            m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
  logic [63:0]     m0_r_data, m1_r_data;
  logic [ID_W-1:0] m0_r_id, m1_r_id;
  logic [1:0]      m0_r_resp, m1_r_resp;
  logic            m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
  logic [ID_W-1:0] m0_b_id, m1_b_id;
  logic [1:0]      m0_b_resp, m1_b_resp;
  logic            s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready;
  logic [31:0]     s_ar_addr, s_aw_addr;
  logic [ID_W:0]   s_ar_id, s_aw_id;
  logic [7:0]      s_ar_len, s_aw_len;
  logic [2:0]      s_ar_size, s_aw_size;
  logic            s_w_valid, s_w_ready, s_w_last;
  logic [63:0]     s_w_data;
  logic            s_r_valid, s_r_ready, s_r_last;
  logic [63:0]     s_r_data;
  logic [ID_W:0]   s_r_id;
  logic [1:0]      s_r_resp;
  logic            s_b_valid, s_b_ready;
  logic [ID_W:0]   s_b_id;
  logic [1:0]      s_b_resp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hp_axi_arbiter #(.ID_W(ID_W), .WORD_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
    .m0_ar_id(m0_ar_id), .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size),
    .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_addr(m0_aw_addr),
    .m0_aw_id(m0_aw_id), .m0_aw_len(m0_aw_len), .m0_aw_size(m0_aw_size),
    .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_data(m0_w_data), .m0_w_last(m0_w_last),
    .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data), .m0_r_id(m0_r_id),
    .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
    .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready), .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
    .m1_ar_id(m1_ar_id), .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size),
    .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr),
    .m1_aw_id(m1_aw_id), .m1_aw_len(m1_aw_len), .m1_aw_size(m1_aw_size),
    .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data), .m1_w_last(m1_w_last),
    .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data), .m1_r_id(m1_r_id),
    .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
    .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready), .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_last(s_w_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_ar_valid = 0; m0_ar_addr = 0; m0_ar_id = 0; m0_ar_len = 0; m0_ar_size = 0;
    m1_ar_valid = 0; m1_ar_addr = 0; m1_ar_id = 0; m1_ar_len = 0; m1_ar_size = 0;
    m0_aw_valid = 0; m0_aw_addr = 0; m0_aw_id = 0; m0_aw_len = 0; m0_aw_size = 0;
    m1_aw_valid = 0; m1_aw_addr = 0; m1_aw_id = 0; m1_aw_len = 0; m1_aw_size = 0;
    m0_w_valid = 0; m0_w_data = 0; m0_w_last = 0;
    m1_w_valid = 0; m1_w_data = 0; m1_w_last = 0;
    m0_r_ready = 0; m1_r_ready = 0; m0_b_ready = 0; m1_b_ready = 0;
    s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
    s_r_valid = 0; s_r_data = 0; s_r_id = 0; s_r_resp = 0; s_r_last = 0;
    s_b_valid = 0; s_b_id = 0; s_b_resp = 0;

    // reset state: readies suppressed even with requests pending
    m0_ar_valid = 1; m1_aw_valid = 1;
    repeat (3) tick();
    chk("rst_m0_ar_ready", m0_ar_ready, 0);
    chk("rst_m1_aw_ready", m1_aw_ready, 0);
    chk("rst_s_ar_valid", s_ar_valid, 0);
    chk("rst_s_aw_valid", s_aw_valid, 0);
    chk("rst_s_ar_addr", s_ar_addr & 32'h0FFF_FFFF, 0);
    chk("rst_s_ar_id", s_ar_id, 0);
    chk("rst_s_aw_len", s_aw_len, 0);
    m0_ar_valid = 0; m1_aw_valid = 0;
    reset_n = 1;
    tick();

    // single read from m0
    m0_ar_valid = 1; m0_ar_addr = 32'h0000_1000; m0_ar_id = 5'd3; m0_ar_len = 8'd7; m0_ar_size = 3'd3;
    #1;
    chk("rd_m0_ar_ready", m0_ar_ready, 1);
    chk("rd_m1_ar_ready", m1_ar_ready, 0);
    chk("rd_s_ar_valid_N", s_ar_valid, 0);
    tick();
    m0_ar_valid = 0;
    #1;
    chk("rd_s_ar_valid", s_ar_valid, 1);
    chk("rd_s_ar_id", s_ar_id, 6'h03);
    chk("rd_s_ar_addr", s_ar_addr, EXP_AR_ADDR);
    chk("rd_s_ar_len", s_ar_len, 7);
    chk("rd_s_ar_size", s_ar_size, 3);
    tick();
    chk("rd_hold_valid", s_ar_valid, 1);
    chk("rd_hold_id", s_ar_id, 6'h03);
    s_ar_ready = 1;
    tick();
    s_ar_ready = 0;
    #1;
    chk("rd_done_valid", s_ar_valid, 0);

    // R steering to m0 and m1
    s_r_valid = 1; s_r_id = 6'h03; s_r_data = 64'hDEAD_BEEF_0123_4567; s_r_resp = 2'b01; s_r_last = 1;
    m0_r_ready = 1; m1_r_ready = 0;
    #1;
    chk("r_m0_valid", m0_r_valid, 1);
    chk("r_m1_valid", m1_r_valid, 0);
    chk("r_m0_id", m0_r_id, 3);
    chk("r_m0_data", m0_r_data, 64'hDEAD_BEEF_0123_4567);
    chk("r_m0_last", m0_r_last, 1);
    chk("r_s_ready0", s_r_ready, 1);
    s_r_id = 6'h23;
    #1;
    chk("r_m1_valid", m1_r_valid, 1);
    chk("r_m0_valid_off", m0_r_valid, 0);
    chk("r_m1_id", m1_r_id, 3);
    chk("r_s_ready1", s_r_ready, 0);
    s_r_valid = 0; m0_r_ready = 0;

    // reset while holding an m1 request (priority currently points at m1)
    tick();
    m1_ar_valid = 1; m1_ar_id = 5'd2; m1_ar_addr = 32'h0000_2000;
    #1;
    chk("hold_m1_grant", m1_ar_ready, 1);
    tick();
    m1_ar_valid = 0;
    #1;
    chk("hold_valid", s_ar_valid, 1);
    chk("hold_id", s_ar_id, 6'h22);
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
    chk("hold_rst_valid", s_ar_valid, 0);
    chk("hold_rst_id", s_ar_id, 0);

    // contention: both request continuously, grants alternate from m0
    m0_ar_valid = 1; m0_ar_id = 5'd1;
    m1_ar_valid = 1; m1_ar_id = 5'd2;
    s_ar_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_m0_ready", m0_ar_ready, (i % 2) == 0);
      chk("ct_m1_ready", m1_ar_ready, (i % 2) == 1);
      tick();
      chk("ct_s_valid", s_ar_valid, 1);
      chk("ct_s_id", s_ar_id, ((i % 2) == 0) ? 6'h01 : 6'h22);
      chk("ct_no_ready", m0_ar_ready | m1_ar_ready, 0);
      tick();
    end
    m0_ar_valid = 0; m1_ar_valid = 0; s_ar_ready = 0;
    tick();

    // write order: m1 AW first, then m0 AW
    s_aw_ready = 1;
    m1_aw_valid = 1; m1_aw_id = 5'd4; m1_aw_len = 8'd3; m1_aw_addr = 32'h0000_3000;
    #1;
    chk("wo_m1_aw_ready", m1_aw_ready, 1);
    tick();
    m1_aw_valid = 0;
    #1;
    chk("wo_s_aw_id1", s_aw_id, 6'h24);
    chk("wo_w_stall_pre", m0_w_ready | m1_w_ready, 0);
    tick();
    m0_aw_valid = 1; m0_aw_id = 5'd6; m0_aw_len = 8'd3;
    #1;
    chk("wo_m0_aw_ready", m0_aw_ready, 1);
    tick();
    m0_aw_valid = 0;
    #1;
    chk("wo_s_aw_id0", s_aw_id, 6'h06);
    tick();
    s_aw_ready = 0;
    s_w_ready = 1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        m1_w_valid = 1; m1_w_data = 64'hB0 + 64'(c); m1_w_last = (c == 3);
        m0_w_valid = 1; m0_w_data = 64'hA0; m0_w_last = 0;
      end else begin
        m1_w_valid = 0; m1_w_last = 0;
        m0_w_valid = 1; m0_w_data = 64'hA0 + 64'(c - 4); m0_w_last = (c == 7);
      end
      #1;
      chk("wo_s_w_valid", s_w_valid, 1);
      chk("wo_s_w_data", s_w_data, (c < 4) ? 64'hB0 + 64'(c) : 64'hA0 + 64'(c - 4));
      chk("wo_s_w_last", s_w_last, (c == 3) || (c == 7));
      chk("wo_m0_w_ready", m0_w_ready, c >= 4);
      chk("wo_m1_w_ready", m1_w_ready, c < 4);
      tick();
    end
    m1_w_valid = 0; m0_w_valid = 1; m0_w_last = 0;
    #1;
    chk("wo_empty_valid", s_w_valid, 0);
    chk("wo_empty_ready", m0_w_ready, 0);
    m0_w_valid = 0; s_w_ready = 0;
    tick();

    // FIFO full: four grants with W stalled, fifth AW waits
    s_aw_ready = 1;
    m0_aw_valid = 1; m0_aw_id = 5'd7; m0_aw_len = 8'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ff_grant", m0_aw_ready, 1);
      tick();
      tick();
    end
    #1;
    chk("ff_full_ready", m0_aw_ready, 0);
    tick();
    chk("ff_full_idle", s_aw_valid, 0);
    chk("ff_full_ready2", m0_aw_ready, 0);
    m0_w_valid = 1; m0_w_data = 64'h55; m0_w_last = 1; s_w_ready = 1;
    #1;
    chk("ff_pop_valid", s_w_valid, 1);
    tick();
    s_w_ready = 0;
    #1;
    chk("ff_release", m0_aw_ready, 1);
    tick();
    m0_aw_valid = 0;
    tick();
    s_w_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ff_drain_valid", s_w_valid, 1);
      tick();
    end
    #1;
    chk("ff_drained", s_w_valid, 0);
    m0_w_valid = 0; m0_w_last = 0; s_w_ready = 0; s_aw_ready = 0;

    // B steering
    s_b_valid = 1; s_b_id = 6'h21; s_b_resp = 2'b10;
    m0_b_ready = 1; m1_b_ready = 0;
    #1;
    chk("b_m1_valid", m1_b_valid, 1);
    chk("b_m0_valid", m0_b_valid, 0);
    chk("b_s_ready", s_b_ready, 0);
    chk("b_m1_id", m1_b_id, 1);
    chk("b_m1_resp", m1_b_resp, 2);
    m1_b_ready = 1;
    #1;
    chk("b_s_ready_on", s_b_ready, 1);
    s_b_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
